sram_multi_port_ctrl: RTL and testbench

- Parametrised external-SRAM controller that arbitrates NUM_CH requesters (e.g. IF, EXE, DMA/VGA) onto one asynchronous SRAM bank.
- Replaces the fixed two-requester, fixed-timing RAM2 controller. Adds configurable width, channel count and access wait states.
- Uses a clean per-channel req/ack handshake instead of activity-tag matching.
- Sits between the pipeline/memory stage and the board SRAM pins.

---
 rtl/sram_multi_port_ctrl_if.sv | 17 +
 rtl/sram_multi_port_ctrl.sv | 150 +++++++++++++++
 tb/tb_sram_multi_port_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sram_multi_port_ctrl_if.sv
// rtl/sram_multi_port_ctrl_if.sv - requester-side request/ack bus of the SRAM controller
interface sram_multi_port_ctrl_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0]        req;
  logic [NUM_CH-1:0]        req_we;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0] req_wdata;
  logic [NUM_CH-1:0]        ack;
  logic [DATA_W-1:0]        rdata;
  logic                     busy;

  modport master (output req, req_we, req_addr, req_wdata, input ack, rdata, busy);
  modport slave  (input req, req_we, req_addr, req_wdata, output ack, rdata, busy);
endinterface

// File: rtl/sram_multi_port_ctrl.sv
// rtl/sram_multi_port_ctrl.sv - NUM_CH-requester arbiter/sequencer for one asynchronous SRAM bank
// Optional SRAM_RR_ARB_EN selects round-robin arbitration instead of fixed priority.
module sram_multi_port_ctrl #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 16,
  parameter int NUM_CH   = 2,
  parameter int WAIT_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_multi_port_ctrl_if.slave bus,
  output logic [ADDR_W-1:0]    sram_addr,
  inout  wire  [DATA_W-1:0]    sram_data,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(WAIT_CYC + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t            state;
  logic [CH_W-1:0]   ch_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              drive_en;
  logic [CNT_W-1:0]  wait_cnt;
  logic [NUM_CH-1:0] ack_q;
  logic [DATA_W-1:0] rdata_q;

  logic              grant_vld;
  logic [CH_W-1:0]   grant_ch;
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;

`ifdef SRAM_RR_ARB_EN
  logic [CH_W-1:0]   rr_ptr;
  logic [NUM_CH-1:0] req_rot;
  logic [CH_W:0]     rr_sum;

  // Rotate so bit 0 is the channel at the pointer, then pick the first set bit.
  assign req_rot = NUM_CH'({bus.req, bus.req} >> rr_ptr);

  always_comb begin
    grant_vld = 1'b0;
    rr_sum    = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        grant_vld = 1'b1;
        rr_sum    = {1'b0, rr_ptr} + (CH_W+1)'(k);
      end
    end
    if (rr_sum >= (CH_W+1)'(NUM_CH)) rr_sum = rr_sum - (CH_W+1)'(NUM_CH);
    grant_ch = rr_sum[CH_W-1:0];
  end
`else
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (bus.req[k]) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'(k);
      end
    end
  end
`endif

  always_comb begin
    g_we    = 1'b0;
    g_addr  = '0;
    g_wdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_ch == CH_W'(k)) begin
        g_we    = bus.req_we[k];
        g_addr  = bus.req_addr[k*ADDR_W +: ADDR_W];
        g_wdata = bus.req_wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ch_q      <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      drive_en  <= 1'b0;
      wait_cnt  <= '0;
      ack_q     <= '0;
      rdata_q   <= '0;
      sram_addr <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
`ifdef SRAM_RR_ARB_EN
      rr_ptr    <= '0;
`endif
    end else begin
      ack_q <= '0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            ch_q      <= grant_ch;
            we_q      <= g_we;
            wdata_q   <= g_wdata;
            sram_addr <= g_addr;
            sram_ce_n <= 1'b0;
            drive_en  <= g_we;
            wait_cnt  <= '0;
            state     <= SETUP;
`ifdef SRAM_RR_ARB_EN
            rr_ptr    <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
`endif
          end
        end
        SETUP: begin
          sram_oe_n <= we_q;
          sram_we_n <= !we_q;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (wait_cnt == CNT_W'(WAIT_CYC - 1)) begin
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            if (!we_q) rdata_q <= sram_data;
            ack_q     <= NUM_CH'(1) << ch_q;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          // Write data stays driven through DONE for hold time after we_n rises.
          sram_ce_n <= 1'b1;
          drive_en  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sram_data = drive_en ? wdata_q : {DATA_W{1'bz}};
  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = (state != IDLE);
endmodule

// File: tb/tb_sram_multi_port_ctrl.sv
// tb/tb_sram_multi_port_ctrl.sv - randomized bench for sram_multi_port_ctrl against a transaction timeline model
module tb_sram_multi_port_ctrl;
  localparam int ADDR_W   = 18;
  localparam int DATA_W   = 16;
  localparam int NUM_CH   = 3;
  localparam int WAIT_CYC = 2;
  localparam int LAST     = 2 + WAIT_CYC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  wire  [DATA_W-1:0] sram_data;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_ce_n, sram_oe_n, sram_we_n;

  sram_multi_port_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

  sram_multi_port_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH), .WAIT_CYC(WAIT_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sram_addr (sram_addr),
    .sram_data (sram_data),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] sram_mem [32];
  logic [DATA_W-1:0] ref_mem  [32];

  assign sram_data = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[4:0]] : {DATA_W{1'bz}};
  always @(posedge sram_we_n) if (rst && !sram_ce_n) sram_mem[sram_addr[4:0]] = sram_data;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [NUM_CH-1:0] ack_q = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  bit                act = 1'b0;
  int                g_cyc, a_ch, a_addr, off;
  bit                a_we, strobe;
  logic [DATA_W-1:0] a_wd;
  int                ptr = 0;

  // Each granted transaction owns the cycles g+1 .. g+2+WAIT_CYC; everything else is idle.
  always @(negedge clk) begin
    ack_q = bus.ack;
    if (!rst) begin
      check("rst_ce_n", sram_ce_n, 1);
      check("rst_oe_n", sram_oe_n, 1);
      check("rst_we_n", sram_we_n, 1);
      check("rst_ack", bus.ack, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_rdata", bus.rdata, 0);
      check("rst_addr", sram_addr, 0);
      act = 1'b0;
      ptr = 0;
    end else if (act) begin
      off    = cyc - g_cyc;
      strobe = (off >= 2) && (off <= 1 + WAIT_CYC);
      check("busy", bus.busy, 1);
      check("ce_n", sram_ce_n, 0);
      check("addr", sram_addr, a_addr);
      check("we_n", sram_we_n, !(a_we && strobe));
      check("oe_n", sram_oe_n, !(!a_we && strobe));
      check("ack", bus.ack, (off == LAST) ? (64'd1 << a_ch) : 64'd0);
      if (a_we) check("wdata_bus", sram_data, a_wd);
      if (off == LAST) begin
        if (a_we) ref_mem[a_addr] = a_wd;
        else check("rdata", bus.rdata, ref_mem[a_addr]);
        act = 1'b0;
      end
    end else begin
      check("idle_busy", bus.busy, 0);
      check("idle_ce_n", sram_ce_n, 1);
      check("idle_oe_n", sram_oe_n, 1);
      check("idle_we_n", sram_we_n, 1);
      check("idle_ack", bus.ack, 0);
      if (bus.req != '0) begin
`ifdef SRAM_RR_ARB_EN
        for (int k = 0; k < NUM_CH; k++) begin
          if (bus.req[(ptr + k) % NUM_CH]) begin
            a_ch = (ptr + k) % NUM_CH;
            break;
          end
        end
        ptr = (a_ch + 1) % NUM_CH;
`else
        for (int k = NUM_CH - 1; k >= 0; k--) if (bus.req[k]) a_ch = k;
`endif
        a_we   = bus.req_we[a_ch];
        a_addr = int'(bus.req_addr[a_ch*ADDR_W +: ADDR_W]);
        a_wd   = bus.req_wdata[a_ch*DATA_W +: DATA_W];
        g_cyc  = cyc;
        act    = 1'b1;
      end
    end
  end

  task automatic issue(input int ch, input bit we, input int addr, input logic [DATA_W-1:0] d);
    bus.req[ch]                      = 1'b1;
    bus.req_we[ch]                   = we;
    bus.req_addr[ch*ADDR_W +: ADDR_W]  = ADDR_W'(addr);
    bus.req_wdata[ch*DATA_W +: DATA_W] = d;
  endtask

  // Requesters hold req until ack, then drop it or present a new request at once.
  task automatic drive_cycle(input int prob);
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ack_q[i] || !bus.req[i]) begin
        if (int'($urandom_range(0, 99)) < prob)
          issue(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), DATA_W'($urandom));
        else
          bus.req[i] = 1'b0;
      end
    end
  endtask

  initial begin
    bit found;
    found         = 1'b0;
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 32; i++) begin
      sram_mem[i] = DATA_W'($urandom);
      ref_mem[i]  = sram_mem[i];
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    @(posedge clk); #1 issue(0, 1'b1, 16, 16'hBEEF);
    repeat (8) drive_cycle(0);
    @(posedge clk); #1 issue(1, 1'b0, 16, 16'h0000);
    repeat (8) drive_cycle(0);
    check("readback_beef", ref_mem[16], 16'hBEEF);
    @(posedge clk); #1;
    issue(0, 1'b0, 3, 16'h0000);
    issue(1, 1'b0, 7, 16'h0000);
    repeat (14) drive_cycle(0);

    repeat (300) drive_cycle(35);
    repeat (40) drive_cycle(100);
    repeat (14) drive_cycle(0);

    @(posedge clk); #1 issue(2, 1'b1, 5, 16'h1234);
    for (int t = 0; t < 10 && !found; t++) begin
      drive_cycle(0);
      if (!sram_we_n) found = 1'b1;
    end
    check("we_n_seen", found, 1);
    #2;
    rst     = 1'b0;
    bus.req = '0;
    #1;
    check("abort_we_n", sram_we_n, 1);
    check("abort_ce_n", sram_ce_n, 1);
    check("abort_busy", bus.busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    issue(1, 1'b0, 5, 16'h0000);
    repeat (8) drive_cycle(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
